tcdm_converter_32_to_cfi: RTL and testbench
===========================================

Name: tcdm_converter_32_to_cfi

Overview:
- Bridges a 32-bit TCDM initiator onto a CFI-tagged TCDM target. The target's data is 32 data bits plus TAG_W tag bits.
- On the request path it inserts the CFI tag into the upper write-data bits, behind a one-entry request register.
- On the response path it strips the tag from read data and checks it against the tag expected for that transaction. Issued transactions are tracked in an outstanding FIFO.
- Sits between 32-bit SoC initiators (peripheral DMA, debug) and CFI-protected L2/TCDM banks.

Parameters:
- ADDR_W, 32, address width.
- TAG_W, 32, CFI tag width. CFI data width = 32+TAG_W.
- MAX_OUTST, 4, maximum issued-but-unanswered CFI transactions (power of two, >=2).
- CHECK_TAG, 1, enables the read-tag comparison.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_req_i  in  1  32-bit side request
- s_add_i  in  ADDR_W  address
- s_wen_i  in  1  1=read, 0=write
- s_wdata_i  in  32  write data
- s_be_i  in  4  byte enables
- s_tag_i  in  TAG_W  CFI tag for this transaction
- s_gnt_o  out  1  grant
- s_r_valid_o  out  1  response valid
- s_r_rdata_o  out  32  read data
- s_r_opc_o  out  1  response error
- m_req_o  out  1  CFI request
- m_add_o  out  ADDR_W  address
- m_wen_o  out  1  write enable (1=read)
- m_wdata_o  out  32+TAG_W  write data {tag, data}
- m_be_o  out  4  byte enables
- m_gnt_i  in  1  CFI grant
- m_r_valid_i  in  1  CFI response valid
- m_r_rdata_i  in  32+TAG_W  CFI read data
- m_r_opc_i  in  1  CFI response error
- tag_err_cnt_o  out  8  saturating tag-mismatch count
- proto_err_o  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset: every output is 0. Request register, FIFO and error state are cleared. Reset mid-transaction discards all state; responses arriving afterwards are treated as unexpected.
- Request register (buf_valid, buf_*):
  - s_gnt_o = s_req_i && (!buf_valid || m_gnt_i) && space_ok.
  - space_ok = (issued + buf_valid) < MAX_OUTST, where issued = FIFO count.
  - On s_req_i && s_gnt_o: capture add, wen, wdata, be, tag into buf_*; set buf_valid.
  - m_req_o = buf_valid. m_* are driven from buf_*.
  - m_wdata_o = {buf_tag, buf_wdata} for writes, and also for reads (tag bits are don't-care there).
  - On m_req_o && m_gnt_i: clear buf_valid unless refilled in the same cycle. A simultaneous drain and refill is a legal back-to-back transfer.
  - Request latency: earliest m_req_o is one cycle after s_req_i && s_gnt_o.
  - buf_* hold stable while m_req_o=1 and m_gnt_i=0.
- Outstanding FIFO, depth MAX_OUTST, entry {wen, tag}:
  - Push on m_req_o && m_gnt_i. Pop on m_r_valid_i.
  - Simultaneous push and pop leaves the count unchanged.
  - A push while full cannot occur; space_ok guarantees it.
- Response path, combinational and in the same cycle as m_r_valid_i:
  - s_r_valid_o = m_r_valid_i.
  - s_r_rdata_o = m_r_rdata_i[31:0].
  - s_r_opc_o = m_r_opc_i || mismatch || empty.
  - mismatch = CHECK_TAG && head.wen && (m_r_rdata_i[32+TAG_W-1:32] != head.tag).
  - Write responses are never tag-checked.
- Error state:
  - tag_err_cnt_o increments on each mismatch response and saturates at 255.
  - m_r_valid_i with the FIFO empty sets proto_err_o sticky until reset. The response is forwarded with s_r_opc_o=1 and no pop.
- Ordering: the CFI target returns responses in order. The FIFO head always corresponds to the current response.

Test Plan:
- Single read, add=0x1C00_0010, tag=0xCAFE_0001; target returns {0xCAFE_0001, 0x1234_5678} 1 cycle after gnt -> m_req_o 1 cycle after s_gnt_o; s_r_rdata_o=0x1234_5678, s_r_opc_o=0, tag_err_cnt_o=0.
- Write, wdata=0xA5A5_A5A5, tag=0x0000_00FF, be=0xF -> m_wdata_o=0x0000_00FF_A5A5_A5A5, m_wen_o=0; response has s_r_opc_o=0 whatever the returned upper bits are.
- Read with tag=0x11 returning upper bits 0x22 -> s_r_opc_o=1, tag_err_cnt_o=1. Repeat 300 times -> tag_err_cnt_o saturates at 255.
- m_gnt_i held low, s_req_i continuous, MAX_OUTST=4 -> one grant then s_gnt_o=0 with buf_* stable. Release m_gnt_i with responses withheld -> exactly 4 CFI handshakes, then s_gnt_o=0 until a response pops.
- Back-to-back reads with m_gnt_i=1 and target latency 1 -> one grant per cycle, no bubbles; responses are in order with the matching tags.
- m_r_valid_i pulse with nothing outstanding -> s_r_valid_o=1, s_r_opc_o=1, proto_err_o=1 and held. rst_i for 1 cycle -> all outputs 0 and proto_err_o cleared.

Source files
------------

// File: rtl/tcdm_converter_32_to_cfi.sv
// Bridge from a 32-bit TCDM initiator to a CFI-tagged TCDM target.
// Requests pass through a one-entry register that inserts the CFI tag above
// the write data. Issued transactions are remembered in an in-order FIFO so
// that each read response can have its tag stripped and checked against the
// tag the initiator supplied.
module tcdm_converter_32_to_cfi #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TAG_W     = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter bit          CHECK_TAG = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                s_req_i,
    input  logic [ADDR_W-1:0]   s_add_i,
    input  logic                s_wen_i,
    input  logic [31:0]         s_wdata_i,
    input  logic [3:0]          s_be_i,
    input  logic [TAG_W-1:0]    s_tag_i,
    output logic                s_gnt_o,
    output logic                s_r_valid_o,
    output logic [31:0]         s_r_rdata_o,
    output logic                s_r_opc_o,
    output logic                m_req_o,
    output logic [ADDR_W-1:0]   m_add_o,
    output logic                m_wen_o,
    output logic [32+TAG_W-1:0] m_wdata_o,
    output logic [3:0]          m_be_o,
    input  logic                m_gnt_i,
    input  logic                m_r_valid_i,
    input  logic [32+TAG_W-1:0] m_r_rdata_i,
    input  logic                m_r_opc_i,
    output logic [7:0]          tag_err_cnt_o,
    output logic                proto_err_o
);
    localparam int unsigned DATA_W = 32 + TAG_W;
    localparam int unsigned PTR_W  = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W  = PTR_W + 1;

    // What the response path needs to know about each issued transaction.
    typedef struct packed {
        logic             wen;
        logic [TAG_W-1:0] tag;
    } outst_t;

    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_add_q, buf_add_d;
    logic              buf_wen_q, buf_wen_d;
    logic [31:0]       buf_wdata_q, buf_wdata_d;
    logic [3:0]        buf_be_q, buf_be_d;
    logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;

    outst_t            fifo_q [MAX_OUTST];
    outst_t            fifo_d [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [7:0]        tag_err_cnt_q, tag_err_cnt_d;
    logic              proto_err_q, proto_err_d;

    logic [CNT_W:0]    occupancy;
    logic              space_ok;
    logic              grant;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              mismatch;
    outst_t            head;

    // Handshake decode: admission control counts the buffered request as
    // already outstanding so the FIFO can never be pushed while full.
    always_comb begin
        occupancy  = {1'b0, count_q} + (CNT_W+1)'(buf_valid_q);
        space_ok   = occupancy < (CNT_W+1)'(MAX_OUTST);
        grant      = !rst_i && s_req_i && (!buf_valid_q || m_gnt_i) && space_ok;
        push       = buf_valid_q && m_gnt_i;
        fifo_empty = (count_q == '0);
        pop        = m_r_valid_i && !fifo_empty;
        head       = fifo_q[rd_ptr_q];
        mismatch   = CHECK_TAG && m_r_valid_i && !fifo_empty && head.wen &&
                     (m_r_rdata_i[DATA_W-1:32] != head.tag);
    end

    // Next state for the request register, FIFO bookkeeping and error state.
    always_comb begin
        buf_valid_d   = buf_valid_q;
        buf_add_d     = buf_add_q;
        buf_wen_d     = buf_wen_q;
        buf_wdata_d   = buf_wdata_q;
        buf_be_d      = buf_be_q;
        buf_tag_d     = buf_tag_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        tag_err_cnt_d = tag_err_cnt_q;
        proto_err_d   = proto_err_q;
        for (int i = 0; i < int'(MAX_OUTST); i++) begin
            fifo_d[i] = fifo_q[i];
        end

        // A refill in the same cycle as a drain wins, giving back-to-back transfers.
        if (grant) begin
            buf_valid_d = 1'b1;
            buf_add_d   = s_add_i;
            buf_wen_d   = s_wen_i;
            buf_wdata_d = s_wdata_i;
            buf_be_d    = s_be_i;
            buf_tag_d   = s_tag_i;
        end else if (push) begin
            buf_valid_d = 1'b0;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{wen: buf_wen_q, tag: buf_tag_q};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (mismatch && tag_err_cnt_q != 8'hFF) begin
            tag_err_cnt_d = tag_err_cnt_q + 8'd1;
        end
        if (m_r_valid_i && fifo_empty) begin
            proto_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_q   <= 1'b0;
            buf_add_q     <= '0;
            buf_wen_q     <= 1'b0;
            buf_wdata_q   <= '0;
            buf_be_q      <= '0;
            buf_tag_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tag_err_cnt_q <= '0;
            proto_err_q   <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_add_q     <= buf_add_d;
            buf_wen_q     <= buf_wen_d;
            buf_wdata_q   <= buf_wdata_d;
            buf_be_q      <= buf_be_d;
            buf_tag_q     <= buf_tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tag_err_cnt_q <= tag_err_cnt_d;
            proto_err_q   <= proto_err_d;
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Output drive; the response path is gated during reset so every output reads 0.
    always_comb begin
        s_gnt_o       = grant;
        s_r_valid_o   = !rst_i && m_r_valid_i;
        s_r_rdata_o   = rst_i ? 32'd0 : m_r_rdata_i[31:0];
        s_r_opc_o     = !rst_i && m_r_valid_i && (m_r_opc_i || mismatch || fifo_empty);
        m_req_o       = buf_valid_q;
        m_add_o       = buf_add_q;
        m_wen_o       = buf_wen_q;
        m_wdata_o     = {buf_tag_q, buf_wdata_q};
        m_be_o        = buf_be_q;
        tag_err_cnt_o = tag_err_cnt_q;
        proto_err_o   = proto_err_q;
    end

endmodule

// File: tb/tb_tcdm_converter_32_to_cfi.sv
// Bench for tcdm_converter_32_to_cfi: directed scenarios plus a random phase,
// all checked cycle by cycle against a queue-based transaction model.
module tb_tcdm_converter_32_to_cfi;
    localparam int MAX_OUTST = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        s_req_i;
    logic [31:0] s_add_i;
    logic        s_wen_i;
    logic [31:0] s_wdata_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_tag_i;
    logic        s_gnt_o;
    logic        s_r_valid_o;
    logic [31:0] s_r_rdata_o;
    logic        s_r_opc_o;
    logic        m_req_o;
    logic [31:0] m_add_o;
    logic        m_wen_o;
    logic [63:0] m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_gnt_i;
    logic        m_r_valid_i;
    logic [63:0] m_r_rdata_i;
    logic        m_r_opc_i;
    logic [7:0]  tag_err_cnt_o;
    logic        proto_err_o;

    tcdm_converter_32_to_cfi #(
        .ADDR_W(32), .TAG_W(32), .MAX_OUTST(MAX_OUTST), .CHECK_TAG(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
        .s_wdata_i(s_wdata_i), .s_be_i(s_be_i), .s_tag_i(s_tag_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
        .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
        .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_gnt_i(m_gnt_i),
        .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i),
        .m_r_opc_i(m_r_opc_i), .tag_err_cnt_o(tag_err_cnt_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: accepted-but-not-issued requests, and issued
    // transactions awaiting their in-order response.
    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] tag;
    } req_t;
    typedef struct {
        logic        wen;
        logic [31:0] tag;
    } ent_t;

    req_t pend[$];
    ent_t outst[$];
    int   m_cnt;
    bit   m_proto;
    int   n_checks;
    int   n_fail;
    int   dut_hs;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    // rmode: 0 no response, 1 response with matching tag, 2 response with
    // upper bits = rtag, 3 response even when nothing is outstanding.
    task automatic step(input logic req, input logic [31:0] add, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] tag, input logic gnt, input int rmode,
                        input logic [31:0] rtag, input logic [31:0] rlo,
                        input logic ropc);
        logic        rv;
        logic [63:0] rd;
        logic        exp_gnt;
        logic        exp_opc;
        logic        mm;
        ent_t        e;
        req_t        r;
        rv = 1'b0;
        rd = {$urandom, rlo};
        if (rmode == 3) begin
            rv = 1'b1;
        end else if (rmode != 0 && outst.size() != 0) begin
            rv = 1'b1;
            rd[63:32] = (rmode == 1) ? outst[0].tag : rtag;
        end
        s_req_i = req; s_add_i = add; s_wen_i = wen; s_wdata_i = wdata;
        s_be_i = be; s_tag_i = tag; m_gnt_i = gnt;
        m_r_valid_i = rv; m_r_rdata_i = rd; m_r_opc_i = ropc;
        @(negedge clk_i);
        exp_gnt = req && (pend.size() == 0 || gnt) &&
                  (outst.size() + pend.size() < MAX_OUTST);
        check_val("s_gnt", 64'(s_gnt_o), 64'(exp_gnt));
        check_val("m_req", 64'(m_req_o), 64'(pend.size() != 0));
        if (pend.size() != 0) begin
            check_val("m_add", 64'(m_add_o), 64'(pend[0].add));
            check_val("m_wen", 64'(m_wen_o), 64'(pend[0].wen));
            check_val("m_wdata", m_wdata_o, {pend[0].tag, pend[0].wdata});
            check_val("m_be", 64'(m_be_o), 64'(pend[0].be));
        end
        check_val("tag_err_cnt", 64'(tag_err_cnt_o), 64'(m_cnt));
        check_val("proto_err", 64'(proto_err_o), 64'(m_proto));
        check_val("s_r_valid", 64'(s_r_valid_o), 64'(rv));
        if (m_req_o && m_gnt_i) dut_hs++;
        if (rv) begin
            if (outst.size() == 0) begin
                exp_opc = 1'b1;
                m_proto = 1'b1;
                $display("resp unexpected rdata=%h opc=%0d", s_r_rdata_o, s_r_opc_o);
            end else begin
                e = outst.pop_front();
                mm = e.wen && (rd[63:32] != e.tag);
                exp_opc = ropc || mm;
                if (mm && m_cnt < 255) m_cnt++;
                $display("resp wen=%0d tag=%h got_tag=%h rdata=%h opc=%0d",
                         e.wen, e.tag, rd[63:32], s_r_rdata_o, s_r_opc_o);
            end
            check_val("s_r_rdata", 64'(s_r_rdata_o), 64'(rd[31:0]));
            check_val("s_r_opc", 64'(s_r_opc_o), 64'(exp_opc));
        end
        if (pend.size() != 0 && gnt) begin
            r = pend.pop_front();
            outst.push_back('{wen: r.wen, tag: r.tag});
        end
        if (exp_gnt) pend.push_back('{add: add, wen: wen, wdata: wdata, be: be, tag: tag});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic gnt, input int rmode);
        step(1'b0, $urandom, 1'b0, $urandom, 4'h0, $urandom, gnt, rmode, $urandom, $urandom, 1'b0);
    endtask

    // Reset with busy inputs; every output must read 0 while reset is held.
    task automatic do_reset();
        rst_i = 1'b1; s_req_i = 1'b1; s_add_i = $urandom; s_wen_i = 1'b1;
        s_wdata_i = $urandom; s_be_i = 4'hF; s_tag_i = $urandom;
        m_gnt_i = 1'b1; m_r_valid_i = 1'b1; m_r_rdata_i = {$urandom, $urandom}; m_r_opc_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_s_gnt", 64'(s_gnt_o), 64'd0);
        check_val("rst_s_r_valid", 64'(s_r_valid_o), 64'd0);
        check_val("rst_s_r_rdata", 64'(s_r_rdata_o), 64'd0);
        check_val("rst_s_r_opc", 64'(s_r_opc_o), 64'd0);
        check_val("rst_m_req", 64'(m_req_o), 64'd0);
        check_val("rst_m_add", 64'(m_add_o), 64'd0);
        check_val("rst_m_wen", 64'(m_wen_o), 64'd0);
        check_val("rst_m_wdata", m_wdata_o, 64'd0);
        check_val("rst_m_be", 64'(m_be_o), 64'd0);
        check_val("rst_tag_err_cnt", 64'(tag_err_cnt_o), 64'd0);
        check_val("rst_proto_err", 64'(proto_err_o), 64'd0);
        rst_i = 1'b0; s_req_i = 1'b0; m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_opc_i = 1'b0;
        pend.delete();
        outst.delete();
        m_cnt = 0;
        m_proto = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        dut_hs   = 0;
        do_reset();

        // Single read with matching tag, response one cycle after the handshake.
        step(1'b1, 32'h1C00_0010, 1'b1, 32'h0, 4'hF, 32'hCAFE_0001, 1'b1, 0, 32'h0, 32'h0, 1'b0);
        idle(1'b1, 0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1, 32'h0, 32'h1234_5678, 1'b0);

        // Write: tag inserted above data; response never tag-checked.
        step(1'b1, 32'h1C00_0020, 1'b0, 32'hA5A5_A5A5, 4'hF, 32'h0000_00FF, 1'b1, 0, 32'h0, 32'h0, 1'b0);
        idle(1'b1, 0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 2, 32'hDEAD_BEEF, $urandom, 1'b0);

        // Repeated tag mismatches: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom, 1'b1, $urandom, 4'hF, 32'h11, 1'b1, 0, 32'h0, 32'h0, 1'b0);
            idle(1'b1, 0);
            step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 2, 32'h22, $urandom, 1'b0);
        end
        check_val("cnt_sat", 64'(tag_err_cnt_o), 64'd255);

        // Stalled target: one grant, buffer held; then exactly 4 handshakes.
        for (int i = 0; i < 5; i++)
            step(1'b1, $urandom, 1'b1, $urandom, 4'h3, $urandom, 1'b0, 0, 32'h0, 32'h0, 1'b0);
        dut_hs = 0;
        for (int i = 0; i < 8; i++)
            step(1'b1, $urandom, 1'b1, $urandom, 4'h3, $urandom, 1'b1, 0, 32'h0, 32'h0, 1'b0);
        check_val("outst_handshakes", 64'(dut_hs), 64'd4);
        for (int i = 0; i < 6; i++) idle(1'b1, 1);

        // Back-to-back reads with latency-1 responses.
        for (int i = 0; i < 12; i++)
            step(1'b1, $urandom, 1'b1, $urandom, 4'hF, $urandom, 1'b1, 1, 32'h0, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1);

        // Unexpected response: flagged and sticky.
        idle(1'b1, 3);
        for (int i = 0; i < 3; i++) idle(1'b1, 0);
        check_val("proto_sticky", 64'(proto_err_o), 64'd1);
        do_reset();

        // Random traffic with random stalls, mismatches and target errors.
        for (int i = 0; i < 1500; i++) begin
            int rm;
            rm = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 7) == 0) ? 2 : 1);
            step(1'(($urandom_range(0, 2)) != 0), $urandom, 1'($urandom), $urandom,
                 4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), rm,
                 $urandom, $urandom, 1'($urandom_range(0, 15) == 0));
        end

        // Reset mid-transaction: later responses are unexpected.
        for (int i = 0; i < 2; i++)
            step(1'b1, $urandom, 1'b1, $urandom, 4'hF, $urandom, 1'b1, 0, 32'h0, 32'h0, 1'b0);
        do_reset();
        idle(1'b0, 3);
        idle(1'b0, 0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
